// File: rtl/int_alu_responder.sv
// Integer ALU responder: captures opcode and two operands from the execution bus,
// computes add/sub/mult in one cycle or an unsigned divide over DivCycles cycles.
module int_alu_responder #(
  parameter int IntegerAluEn = 4,
  parameter int DivCycles    = 32
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic [15:0]  address,
  input  logic [255:0] ExecDataOut,
  input  logic         nRead,
  input  logic         nWrite,
  input  logic         opcodeonBus,
  input  logic         src1onBus,
  input  logic         src2onBus,
  input  logic         destonBus,
  output logic [255:0] AluDataOut,
  output logic         AluBusy,
  output logic         AluErr
);

  localparam int CntW = $clog2(DivCycles + 1);

  typedef enum logic [2:0] {IDLE, HAVE_OP, HAVE_S1, COMPUTE, DIV, DONE} state_t;

  state_t            state_r, state_s;
  logic [7:0]        opcode_r, opcode_s;
  logic [31:0]       a_r, a_s, b_r, b_s, result_r, result_s;
  logic [31:0]       rem_r, rem_s, quo_r, quo_s;
  logic [CntW-1:0]   cnt_r, cnt_s;
  logic              busy_r, busy_s, err_r, err_s;
  logic              sel_s;
  logic [32:0]       shifted_s, trial_s;
  logic              unused_s;

  assign sel_s     = (address[15:12] == 4'(IntegerAluEn));
  // One restoring-divide step: shift in the next dividend bit, try subtracting B.
  assign shifted_s = {rem_r, quo_r[31]};
  assign trial_s   = shifted_s - {1'b0, b_r};
  assign unused_s  = ^{nRead, destonBus, ExecDataOut[255:32]};

  assign AluDataOut = (state_r == DONE && sel_s && !nWrite) ? {224'b0, result_r} : 256'b0;
  assign AluBusy    = busy_r;
  assign AluErr     = err_r;

  // Next-state and datapath update; an opcode strobe overrides everything else.
  always_comb begin
    state_s  = state_r;
    opcode_s = opcode_r;
    a_s      = a_r;
    b_s      = b_r;
    result_s = result_r;
    rem_s    = rem_r;
    quo_s    = quo_r;
    cnt_s    = cnt_r;
    busy_s   = busy_r;
    err_s    = err_r;
    if (sel_s && !opcodeonBus) begin
      opcode_s = ExecDataOut[7:0];
      err_s    = 1'b0;
      busy_s   = 1'b0;
      state_s  = HAVE_OP;
    end else begin
      if (sel_s && !nWrite && state_r != DONE) begin
        err_s = 1'b1;
      end else begin
        err_s = err_r;
      end
      case (state_r)
        HAVE_OP: begin
          if (sel_s && !src1onBus) begin
            a_s     = ExecDataOut[31:0];
            state_s = HAVE_S1;
          end else begin
            state_s = HAVE_OP;
          end
        end
        HAVE_S1: begin
          // src1 outranks src2 even though it is ignored here
          if (sel_s && !src1onBus) begin
            state_s = HAVE_S1;
          end else if (sel_s && !src2onBus) begin
            b_s     = ExecDataOut[31:0];
            state_s = COMPUTE;
          end else begin
            state_s = HAVE_S1;
          end
        end
        COMPUTE: begin
          state_s = DONE;
          case (opcode_r)
            8'h10: result_s = a_r + b_r;
            8'h11: result_s = a_r - b_r;
            8'h12: result_s = a_r * b_r;
            8'h13: begin
              if (b_r == 32'h0) begin
                result_s = 32'hFFFF_FFFF;
                err_s    = 1'b1;
              end else begin
                state_s = DIV;
                busy_s  = 1'b1;
                rem_s   = 32'h0;
                quo_s   = a_r;
                cnt_s   = {CntW{1'b0}};
              end
            end
            default: begin
              result_s = 32'h0;
              err_s    = 1'b1;
            end
          endcase
        end
        DIV: begin
          quo_s = {quo_r[30:0], ~trial_s[32]};
          rem_s = trial_s[32] ? shifted_s[31:0] : trial_s[31:0];
          cnt_s = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
          if (cnt_r == CntW'(DivCycles - 1)) begin
            state_s  = DONE;
            busy_s   = 1'b0;
            result_s = {quo_r[30:0], ~trial_s[32]};
          end else begin
            state_s = DIV;
          end
        end
        default: state_s = state_r;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_r  <= IDLE;
      opcode_r <= 8'h0;
      a_r      <= 32'h0;
      b_r      <= 32'h0;
      result_r <= 32'h0;
      rem_r    <= 32'h0;
      quo_r    <= 32'h0;
      cnt_r    <= {CntW{1'b0}};
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      opcode_r <= opcode_s;
      a_r      <= a_s;
      b_r      <= b_s;
      result_r <= result_s;
      rem_r    <= rem_s;
      quo_r    <= quo_s;
      cnt_r    <= cnt_s;
      busy_r   <= busy_s;
      err_r    <= err_s;
    end
  end

endmodule

// File: tb/tb_int_alu_responder.sv
// Self-checking bench for int_alu_responder: directed vector table, corner-case
// sequences and random operations checked against an arithmetic reference model.
module tb_int_alu_responder;

  logic         Clk = 1'b0;
  logic         nReset;
  logic [15:0]  address;
  logic [255:0] ExecDataOut;
  logic         nRead, nWrite, opcodeonBus, src1onBus, src2onBus, destonBus;
  logic [255:0] AluDataOut;
  logic         AluBusy, AluErr;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] SelAddr = 16'h4000;

  int_alu_responder dut (
    .Clk(Clk), .nReset(nReset), .address(address), .ExecDataOut(ExecDataOut),
    .nRead(nRead), .nWrite(nWrite), .opcodeonBus(opcodeonBus), .src1onBus(src1onBus),
    .src2onBus(src2onBus), .destonBus(destonBus), .AluDataOut(AluDataOut),
    .AluBusy(AluBusy), .AluErr(AluErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b, res;
    logic        err;
    int          busy;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic strobe(input int which, input logic [31:0] data);
    ExecDataOut = {224'b0, data};
    case (which)
      0: opcodeonBus = 1'b0;
      1: src1onBus   = 1'b0;
      2: src2onBus   = 1'b0;
      default: destonBus = 1'b0;
    endcase
    tick();
    {opcodeonBus, src1onBus, src2onBus, destonBus} = 4'hF;
  endtask

  task automatic read_check(input string name, input logic [31:0] exp, input logic exp_err);
    nWrite = 1'b0;
    #1;
    check({name, " data"}, AluDataOut, {224'b0, exp});
    check({name, " err"}, {255'b0, AluErr}, {255'b0, exp_err});
    tick();
    nWrite = 1'b1;
  endtask

  // Counts busy cycles after the COMPUTE edge; bounded wait
  task automatic wait_busy(output int n);
    tick();
    n = 0;
    while (AluBusy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    strobe(0, {24'b0, op});
    strobe(1, a);
    strobe(2, b);
    wait_busy(n);
  endtask

  function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int busy);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    e = 1'b0;
    busy = 0;
    case (op)
      8'h10: r = a + b;
      8'h11: r = a - b;
      8'h12: r = p[31:0];
      8'h13: begin
        if (b == 32'h0) begin
          r = 32'hFFFF_FFFF;
          e = 1'b1;
        end else begin
          r = a / b;
          busy = 32;
        end
      end
      default: begin
        r = 32'h0;
        e = 1'b1;
      end
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] r;
    logic e;
    int eb;
    logic [7:0] op;
    logic [31:0] a, b;

    vecs[0] = '{8'h10, 32'h5, 32'h7, 32'hC, 1'b0, 0};
    vecs[1] = '{8'h11, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0, 0};
    vecs[2] = '{8'h12, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0, 0};
    vecs[3] = '{8'h13, 32'd100, 32'd7, 32'd14, 1'b0, 32};
    vecs[4] = '{8'h13, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[5] = '{8'hFF, 32'h1, 32'h2, 32'h0, 1'b1, 0};
    vecs[6] = '{8'h10, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0};
    vecs[7] = '{8'h13, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1'b0, 32};

    address = SelAddr;
    ExecDataOut = 256'b0;
    {nRead, nWrite, opcodeonBus, src1onBus, src2onBus, destonBus} = 6'h3F;
    nReset = 1'b0;
    #1;
    check("reset data", AluDataOut, 256'b0);
    check("reset busy", {255'b0, AluBusy}, 256'b0);
    check("reset err", {255'b0, AluErr}, 256'b0);
    tick();
    nReset = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check($sformatf("vec%0d busy cycles", i), 256'(n), 256'(vecs[i].busy));
      read_check($sformatf("vec%0d", i), vecs[i].res, vecs[i].err);
    end

    // Repeated reads, unselected read, unselected strobes in DONE
    run_op(8'h10, 32'd5, 32'd7, n);
    read_check("reread1", 32'hC, 1'b0);
    read_check("reread2", 32'hC, 1'b0);
    address = 16'h0000;
    nWrite = 1'b0;
    #1;
    check("unselected read", AluDataOut, 256'b0);
    ExecDataOut = 256'h11;
    {opcodeonBus, src1onBus, src2onBus, destonBus} = 4'h0;
    tick();
    {opcodeonBus, src1onBus, src2onBus, destonBus} = 4'hF;
    nWrite = 1'b1;
    address = SelAddr;
    read_check("after unselected strobes", 32'hC, 1'b0);

    // Read outside DONE flags an error
    strobe(0, 32'h10);
    nWrite = 1'b0;
    #1;
    check("early read data", AluDataOut, 256'b0);
    tick();
    nWrite = 1'b1;
    check("early read err", {255'b0, AluErr}, 256'h1);
    strobe(1, 32'd2);
    strobe(2, 32'd3);
    tick();
    read_check("after early read", 32'd5, 1'b1);

    // Opcode and src1 on the same edge; src2 before src1 is ignored
    ExecDataOut = 256'h10;
    opcodeonBus = 1'b0;
    src1onBus = 1'b0;
    tick();
    {opcodeonBus, src1onBus} = 2'b11;
    strobe(2, 32'h20);
    strobe(1, 32'h30);
    strobe(2, 32'h40);
    wait_busy(n);
    read_check("opcode priority", 32'h70, 1'b0);

    // Abort a divide at DIV cycle 5
    strobe(0, 32'h13);
    strobe(1, 32'd100);
    strobe(2, 32'd7);
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("busy before abort", {255'b0, AluBusy}, 256'h1);
    strobe(0, 32'h13);
    check("busy after abort", {255'b0, AluBusy}, 256'b0);
    strobe(1, 32'd200);
    strobe(2, 32'd9);
    wait_busy(n);
    check("post-abort busy cycles", 256'(n), 256'd32);
    read_check("post-abort", 32'd22, 1'b0);

    // Reset at DIV cycle 10
    strobe(0, 32'h13);
    strobe(1, 32'd100);
    strobe(2, 32'd7);
    tick();
    for (int i = 0; i < 9; i++) tick();
    check("busy before reset", {255'b0, AluBusy}, 256'h1);
    #2;
    nReset = 1'b0;
    #1;
    check("mid-div reset busy", {255'b0, AluBusy}, 256'b0);
    check("mid-div reset data", AluDataOut, 256'b0);
    check("mid-div reset err", {255'b0, AluErr}, 256'b0);
    tick();
    nReset = 1'b1;
    tick();
    run_op(8'h10, 32'd1, 32'd1, n);
    read_check("after reset add", 32'd2, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: op = 8'h10;
        1: op = 8'h11;
        2: op = 8'h12;
        3: op = 8'h13;
        default: op = 8'($urandom);
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      model(op, a, b, r, e, eb);
      run_op(op, a, b, n);
      check($sformatf("rand%0d op%h busy cycles", i, op), 256'(n), 256'(eb));
      read_check($sformatf("rand%0d op%h", i, op), r, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
